// File: rtl/femtorv_spi_flash_responder_pkg.sv
// Shared definitions for the FemtoRV32 SPI-flash read responder.
// Contents: flash command opcode, transaction bit counts, the one-hot
// state encoding and a byte-swap helper used when the received word is
// committed to the bus.
package femtorv_spi_flash_responder_pkg;

    localparam logic [7:0] SPI_CMD_READ      = 8'h03;
    localparam int         SPI_CMD_ADDR_BITS = 32;
    localparam int         SPI_DATA_BITS     = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_SEND = 3'b010,
        ST_RECV = 3'b100
    } state_t;

    // Flash byte 0 arrives first and ends up in the top byte of the shift
    // register; the bus wants it in bits [7:0].
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/femtorv_spi_flash_responder.sv
// FemtoRV32 memory-bus responder that reads one 32-bit word from SPI flash
// with the READ (0x03) command on every accepted read strobe.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   mem_addr            byte address from the core (bits [ADDR_WIDTH-1:2] used)
//   mem_rstrb           decoded read strobe, one-cycle pulse
//   mem_rdata           little-endian read word, held until the next read
//   mem_rbusy           high for the 128 cycles of a transaction
//   mem_wbusy           always 0 (read-only device)
//   spi_cs_n, spi_clk   flash select (active low) and mode-0 clock
//   spi_mosi, spi_miso  serial command/address out, data in
// Each SPI bit spans two clk cycles (phase 0: clock low, phase 1: clock
// high); MISO is sampled on the edge that ends phase 1.
module femtorv_spi_flash_responder
    import femtorv_spi_flash_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 24,
    parameter logic [ADDR_WIDTH-1:0] FLASH_OFFSET = 24'h020000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    output logic        mem_wbusy,
    output logic        spi_cs_n,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam logic [5:0] LAST_SEND_BIT = 6'(SPI_CMD_ADDR_BITS - 1);
    localparam logic [5:0] LAST_RECV_BIT = 6'(SPI_DATA_BITS - 1);

    state_t                         state_r, state_s;
    logic [SPI_CMD_ADDR_BITS-1:0]   shreg_r, shreg_s;
    logic [5:0]                     bit_cnt_r, bit_cnt_s;
    logic                           phase_r, phase_s;
    logic                           cs_n_r, cs_n_s;
    logic                           sclk_r, sclk_s;
    logic                           mosi_r, mosi_s;
    logic                           rbusy_r, rbusy_s;
    logic [SPI_DATA_BITS-1:0]       rdata_r, rdata_s;
    logic [ADDR_WIDTH-1:0]          flash_addr_s;
    logic [SPI_DATA_BITS-1:0]       rx_word_s;
    logic                           unused_addr_bits_s;

    // Word-aligned flash address; the sum wraps naturally at ADDR_WIDTH bits.
    assign flash_addr_s = {mem_addr[ADDR_WIDTH-1:2], 2'b00} + FLASH_OFFSET;
    assign rx_word_s    = {shreg_r[SPI_DATA_BITS-2:0], spi_miso};

    // Address bits outside the flash window and the byte lane are don't-care.
    assign unused_addr_bits_s = ^{mem_addr[31:ADDR_WIDTH], mem_addr[1:0]};

    assign mem_rdata = rdata_r;
    assign mem_rbusy = rbusy_r;
    assign mem_wbusy = 1'b0;
    assign spi_cs_n  = cs_n_r;
    assign spi_clk   = sclk_r;
    assign spi_mosi  = mosi_r;

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_s   = state_r;
        shreg_s   = shreg_r;
        bit_cnt_s = bit_cnt_r;
        phase_s   = phase_r;
        cs_n_s    = cs_n_r;
        sclk_s    = sclk_r;
        mosi_s    = mosi_r;
        rbusy_s   = rbusy_r;
        rdata_s   = rdata_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_rstrb) begin
                    shreg_s   = {SPI_CMD_READ, flash_addr_s};
                    bit_cnt_s = 6'd0;
                    phase_s   = 1'b0;
                    cs_n_s    = 1'b0;
                    sclk_s    = 1'b0;
                    mosi_s    = SPI_CMD_READ[7];
                    rbusy_s   = 1'b1;
                    state_s   = ST_SEND;
                end else begin
                    cs_n_s  = 1'b1;
                    sclk_s  = 1'b0;
                    mosi_s  = 1'b0;
                    rbusy_s = 1'b0;
                end
            end
            ST_SEND: begin
                if (!phase_r) begin
                    phase_s = 1'b1;
                    sclk_s  = 1'b1;
                end else begin
                    phase_s = 1'b0;
                    sclk_s  = 1'b0;
                    if (bit_cnt_r == LAST_SEND_BIT) begin
                        // MOSI parks low for the whole data phase.
                        bit_cnt_s = 6'd0;
                        mosi_s    = 1'b0;
                        state_s   = ST_RECV;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 6'd1;
                        shreg_s   = {shreg_r[SPI_CMD_ADDR_BITS-2:0], 1'b0};
                        mosi_s    = shreg_r[SPI_CMD_ADDR_BITS-2];
                    end
                end
            end
            ST_RECV: begin
                if (!phase_r) begin
                    phase_s = 1'b1;
                    sclk_s  = 1'b1;
                end else begin
                    phase_s = 1'b0;
                    sclk_s  = 1'b0;
                    shreg_s = rx_word_s;
                    if (bit_cnt_r == LAST_RECV_BIT) begin
                        rdata_s   = byte_swap32(rx_word_s);
                        rbusy_s   = 1'b0;
                        cs_n_s    = 1'b1;
                        bit_cnt_s = 6'd0;
                        state_s   = ST_IDLE;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 6'd1;
                    end
                end
            end
            default: begin
                // Illegal encoding: drop the bus back to a safe idle.
                state_s   = ST_IDLE;
                bit_cnt_s = 6'd0;
                phase_s   = 1'b0;
                cs_n_s    = 1'b1;
                sclk_s    = 1'b0;
                mosi_s    = 1'b0;
                rbusy_s   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset discards any
    // in-flight transaction and clears the read word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            shreg_r   <= '0;
            bit_cnt_r <= 6'd0;
            phase_r   <= 1'b0;
            cs_n_r    <= 1'b1;
            sclk_r    <= 1'b0;
            mosi_r    <= 1'b0;
            rbusy_r   <= 1'b0;
            rdata_r   <= '0;
        end else begin
            state_r   <= state_s;
            shreg_r   <= shreg_s;
            bit_cnt_r <= bit_cnt_s;
            phase_r   <= phase_s;
            cs_n_r    <= cs_n_s;
            sclk_r    <= sclk_s;
            mosi_r    <= mosi_s;
            rbusy_r   <= rbusy_s;
            rdata_r   <= rdata_s;
        end
    end

endmodule
